icache_unit: RTL and testbench
==============================

ICACHE_UNIT -- requirements
Module: icache_unit

Interface
REQ-001 The block SHALL have parameter INDEX_WIDTH, default 4, meaning log2 of the line count (16 direct-mapped lines).
REQ-002 The block SHALL have parameter LINE_WIDTH, default 128, meaning the cache line in bits (16 bytes, offset addr[3:0]).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low, with ports named as the codebase does:
  clk  in  1  clock, all state updates on the rising edge
  rst  in  1  asynchronous reset, active-low
REQ-004 The block SHALL provide these ports:
  rdy  in  1  global enable; low freezes all state and outputs
  flush  in  1  discard the pending fetch
  valid_from_fetcher  in  1  fetch request
  addr_from_fetcher  in  32  byte address; addr[1:0] ignored
  ready_to_fetcher  out  1  one-cycle response pulse
  inst_to_fetcher  out  32  instruction word, valid while ready_to_fetcher=1
  valid_to_mem_ctrler  out  1  line-fill request
  addr_to_mem_ctrler  out  32  line address, addr[3:0]=0
  ready_from_mem_ctrler  in  1  one-cycle line-delivered pulse
  data_from_mem_ctrler  in  LINE_WIDTH  delivered line, byte k at [8k+7:8k]

Function
REQ-005 Storage SHALL be 2^INDEX_WIDTH entries of {valid bit, tag = addr[31:4+INDEX_WIDTH], line}; index = addr[3+INDEX_WIDTH:4].
REQ-006 Word select SHALL be addr[3:2]; word w = line[32w+31:32w], little-endian.
REQ-007 FSM states SHALL be IDLE and MISS; reset state IDLE.
REQ-008 IDLE: valid_from_fetcher=1, flush=0, ready_to_fetcher=0, hit -> next edge ready_to_fetcher=1 with the selected word; state stays IDLE (1-cycle hit latency).
REQ-009 IDLE: request misses -> next edge state=MISS, valid_to_mem_ctrler=1, addr_to_mem_ctrler={addr[31:4],4'b0}; the missed address is latched internally.
REQ-010 MISS: valid_to_mem_ctrler and addr_to_mem_ctrler SHALL stay constant until ready_from_mem_ctrler=1, because the controller re-reads the address every cycle of the burst.
REQ-011 MISS with ready_from_mem_ctrler=1 -> same edge: write the line, tag and valid=1 into the indexed entry; valid_to_mem_ctrler=0; state=IDLE; ready_to_fetcher=1 with the word taken from data_from_mem_ctrler using the latched addr[3:2], unless cancelled per REQ-013.
REQ-012 In a cycle where ready_to_fetcher=1, a new request SHALL NOT be accepted; the fetcher changes its address in that cycle.
REQ-013 flush=1 in IDLE -> no response on the next edge. flush=1 in MISS (or in the ready cycle) -> the request stays outstanding (the controller cannot abort); the line is still filled; the pending response is cancelled (sticky cancel bit, cleared on returning to IDLE).
REQ-014 ready_to_fetcher SHALL be a single-cycle pulse; it is never high two consecutive cycles for the same request.
REQ-015 A refill SHALL overwrite the indexed entry unconditionally; there is no write-back, as instruction memory is read-only.
REQ-016 rdy=0 SHALL hold state, array contents and all outputs unchanged, including while a pulse is high. The mem controller is frozen by the same rdy.
REQ-017 valid_from_fetcher=0 in IDLE SHALL produce no activity.

Reset
REQ-018 rst=0 SHALL immediately clear all valid bits, state=IDLE, cancel bit=0, ready_to_fetcher=0, inst_to_fetcher=0, valid_to_mem_ctrler=0 and addr_to_mem_ctrler=0, independent of clk and rdy.
REQ-019 Reset in MISS SHALL abandon the fill; the first request after reset always misses.

Verification
REQ-020 After reset, fetch 0x0000_1004 with a memory line whose word1=0xDEADBEEF -> valid_to_mem_ctrler=1 with addr 0x0000_1000 until the ready pulse; one cycle after it, ready_to_fetcher=1 and inst=0xDEADBEEF.
REQ-021 Then fetch 0x0000_100C -> hit; ready_to_fetcher=1 one cycle later with word3; no valid_to_mem_ctrler.
REQ-022 Fetch 0x0000_2004 (same index 0, different tag) -> miss, refill; a re-fetch of 0x0000_1004 then misses again.
REQ-023 flush asserted during the miss on 0x0000_3000 -> valid held until the ready pulse, no ready_to_fetcher; a following fetch of 0x0000_3000 hits.
REQ-024 rdy=0 for 3 cycles in MISS and during a ready_to_fetcher pulse -> addr, valid and the pulse are held unchanged; behaviour resumes when rdy=1.
REQ-025 rst asserted in MISS -> outputs 0 immediately; a re-fetch of the same address misses.

Source files
------------

// File: rtl/icache_unit.sv
// ---------------------------------------------------------------------------
// icache_unit -- direct-mapped, read-only instruction cache.
//
// Serves 32-bit instruction fetches from 2^INDEX_WIDTH lines of LINE_WIDTH
// bits. A hit answers one cycle after the request. A miss raises a line-fill
// request to the memory controller and answers once the line arrives.
//
// Ports
//   clk                    in   clock, all state updates on the rising edge
//   rst                    in   asynchronous reset, active-low
//   rdy                    in   global enable; low freezes all state/outputs
//   flush                  in   discard the pending fetch
//   valid_from_fetcher     in   fetch request
//   addr_from_fetcher      in   [31:0] byte address, bits [1:0] ignored
//   ready_to_fetcher       out  one-cycle response pulse
//   inst_to_fetcher        out  [31:0] instruction word, valid with the pulse
//   valid_to_mem_ctrler    out  line-fill request
//   addr_to_mem_ctrler     out  [31:0] line address, bits [3:0] = 0
//   ready_from_mem_ctrler  in   one-cycle line-delivered pulse
//   data_from_mem_ctrler   in   [LINE_WIDTH-1:0] line, byte k at [8k+7:8k]
// ---------------------------------------------------------------------------
module icache_unit #(
    parameter int INDEX_WIDTH = 4,
    parameter int LINE_WIDTH  = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  flush,
    input  logic                  valid_from_fetcher,
    input  logic [31:0]           addr_from_fetcher,
    output logic                  ready_to_fetcher,
    output logic [31:0]           inst_to_fetcher,
    output logic                  valid_to_mem_ctrler,
    output logic [31:0]           addr_to_mem_ctrler,
    input  logic                  ready_from_mem_ctrler,
    input  logic [LINE_WIDTH-1:0] data_from_mem_ctrler
);

    localparam int LINES     = 1 << INDEX_WIDTH;
    localparam int TAG_WIDTH = 28 - INDEX_WIDTH;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    // Architectural state
    state_t                 state_r;
    logic                   cancel_r;
    logic [LINES-1:0]       valid_r;
    logic [TAG_WIDTH-1:0]   tag_r  [0:LINES-1];
    logic [LINE_WIDTH-1:0]  line_r [0:LINES-1];
    logic [27:0]            miss_line_r;   // line address of the outstanding fill
    logic [1:0]             miss_word_r;   // word the fetcher asked for

    // Decoded request / fill fields
    logic [INDEX_WIDTH-1:0] req_idx_s;
    logic [TAG_WIDTH-1:0]   req_tag_s;
    logic [1:0]             req_word_s;
    logic [INDEX_WIDTH-1:0] fill_idx_s;
    logic [TAG_WIDTH-1:0]   fill_tag_s;
    logic                   hit_s;
    logic [31:0]            hit_word_s;
    logic [31:0]            fill_word_s;

    // FSM decisions
    state_t                 state_s;
    logic                   cancel_s;
    logic                   hit_go_s;
    logic                   miss_go_s;
    logic                   fill_s;
    logic                   respond_s;

    assign req_idx_s   = addr_from_fetcher[3+INDEX_WIDTH:4];
    assign req_tag_s   = addr_from_fetcher[31:4+INDEX_WIDTH];
    assign req_word_s  = addr_from_fetcher[3:2];
    assign fill_idx_s  = miss_line_r[INDEX_WIDTH-1:0];
    assign fill_tag_s  = miss_line_r[27:INDEX_WIDTH];

    assign hit_s       = valid_r[req_idx_s] && (tag_r[req_idx_s] == req_tag_s);
    assign hit_word_s  = line_r[req_idx_s][{req_word_s, 5'b00000} +: 32];
    assign fill_word_s = data_from_mem_ctrler[{miss_word_r, 5'b00000} +: 32];

    assign addr_to_mem_ctrler = {miss_line_r, 4'h0};

    // Next-state logic: accept requests in IDLE, wait for the line in MISS
    always_comb begin
        state_s   = state_r;
        cancel_s  = cancel_r;
        hit_go_s  = 1'b0;
        miss_go_s = 1'b0;
        fill_s    = 1'b0;
        respond_s = 1'b0;
        case (state_r)
            IDLE: begin
                // No acceptance while a response is on the bus: the fetcher
                // is switching its address in that cycle.
                if (valid_from_fetcher && !flush && !ready_to_fetcher) begin
                    if (hit_s) begin
                        hit_go_s = 1'b1;
                    end else begin
                        miss_go_s = 1'b1;
                        state_s   = MISS;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            MISS: begin
                // The controller cannot abort a burst, so a flush only
                // suppresses the response; the line is still installed.
                if (ready_from_mem_ctrler) begin
                    fill_s    = 1'b1;
                    respond_s = !(cancel_r || flush);
                    cancel_s  = 1'b0;
                    state_s   = IDLE;
                end else begin
                    cancel_s  = cancel_r || flush;
                end
            end
            default: begin
                state_s  = IDLE;
                cancel_s = 1'b0;
            end
        endcase
    end

    // Control state and fetcher/memory-side output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r             <= IDLE;
            cancel_r            <= 1'b0;
            valid_r             <= '0;
            ready_to_fetcher    <= 1'b0;
            inst_to_fetcher     <= 32'h0000_0000;
            valid_to_mem_ctrler <= 1'b0;
            miss_line_r         <= 28'h000_0000;
            miss_word_r         <= 2'b00;
        end else if (rdy) begin
            state_r          <= state_s;
            cancel_r         <= cancel_s;
            ready_to_fetcher <= hit_go_s || respond_s;
            if (hit_go_s) begin
                inst_to_fetcher <= hit_word_s;
            end else if (respond_s) begin
                inst_to_fetcher <= fill_word_s;
            end else begin
                inst_to_fetcher <= inst_to_fetcher;
            end
            if (miss_go_s) begin
                valid_to_mem_ctrler <= 1'b1;
                miss_line_r         <= addr_from_fetcher[31:4];
                miss_word_r         <= req_word_s;
            end else if (fill_s) begin
                valid_to_mem_ctrler <= 1'b0;
            end else begin
                valid_to_mem_ctrler <= valid_to_mem_ctrler;
            end
            if (fill_s) begin
                valid_r[fill_idx_s] <= 1'b1;
            end else begin
                valid_r <= valid_r;
            end
        end else begin
            state_r <= state_r;
        end
    end

    // Tag and data arrays: only meaningful where the valid bit is set
    always_ff @(posedge clk) begin
        if (rdy && fill_s) begin
            tag_r[fill_idx_s]  <= fill_tag_s;
            line_r[fill_idx_s] <= data_from_mem_ctrler;
        end
    end

endmodule

// File: tb/tb_icache_unit.sv
// ---------------------------------------------------------------------------
// tb_icache_unit -- self-checking bench for icache_unit.
// A transaction-level model (per-index valid/line-address/line table plus a
// deterministic backing memory) predicts hit/miss and the returned word.
// Inputs change on the falling edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_icache_unit;

    logic         clk;
    logic         rst;
    logic         rdy;
    logic         flush;
    logic         valid_f;
    logic [31:0]  addr_f;
    logic         ready_f;
    logic [31:0]  inst_f;
    logic         valid_m;
    logic [31:0]  addr_m;
    logic         ready_m;
    logic [127:0] data_m;

    int checks   = 0;
    int failures = 0;

    // Reference model: which line address each index holds
    bit           mdl_valid [16];
    logic [27:0]  mdl_laddr [16];
    logic [127:0] mdl_line  [16];

    icache_unit #(.INDEX_WIDTH(4), .LINE_WIDTH(128)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .rdy                   (rdy),
        .flush                 (flush),
        .valid_from_fetcher    (valid_f),
        .addr_from_fetcher     (addr_f),
        .ready_to_fetcher      (ready_f),
        .inst_to_fetcher       (inst_f),
        .valid_to_mem_ctrler   (valid_m),
        .addr_to_mem_ctrler    (addr_m),
        .ready_from_mem_ctrler (ready_m),
        .data_from_mem_ctrler  (data_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Backing memory contents; line 0x0000_1000 carries 0xDEADBEEF in word 1
    function automatic logic [127:0] mem_line(input logic [27:0] la);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) begin
            l[32*w +: 32] = (({la, 4'h0} + 32'(w * 4)) * 32'h9E37_79B1) ^ 32'h1357_9BDF;
        end
        if (la == 28'h000_0100) begin
            l[63:32] = 32'hDEAD_BEEF;
        end
        return l;
    endfunction

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mdl_valid[i] = 1'b0;
    endtask

    // One fetch. fl: 0 none, 1 flush while waiting, 2 flush with the line pulse.
    // stall: rdy low 3 cycles in MISS and 3 cycles during the response pulse.
    task automatic fetch(input logic [31:0] a, input int dly, input int fl, input bit stall);
        logic [3:0]   idx;
        bit           hit;
        bit           cancel;
        logic [127:0] line;
        logic [31:0]  word;
        idx    = a[7:4];
        hit    = mdl_valid[idx] && (mdl_laddr[idx] == a[31:4]);
        cancel = 1'b0;
        valid_f = 1'b1; addr_f = a; flush = 1'b0; rdy = 1'b1;
        @(negedge clk);
        valid_f = 1'b0; addr_f = $urandom;
        if (hit) begin
            word = mdl_line[idx][{a[3:2], 5'b00000} +: 32];
            check("hit_no_fill", {31'b0, valid_m}, 32'd0);
        end else begin
            check("miss_valid", {31'b0, valid_m}, 32'd1);
            check("miss_addr", addr_m, {a[31:4], 4'h0});
            check("miss_no_rsp", {31'b0, ready_f}, 32'd0);
            line = mem_line(a[31:4]);
            for (int c = 0; c < dly; c++) begin
                rdy   = !(stall && c < 3);
                flush = (fl == 1) && (c == dly - 1);
                @(negedge clk);
                check("wait_valid", {31'b0, valid_m}, 32'd1);
                check("wait_addr", addr_m, {a[31:4], 4'h0});
                check("wait_no_rsp", {31'b0, ready_f}, 32'd0);
            end
            rdy = 1'b1; ready_m = 1'b1; data_m = line; flush = (fl == 2);
            cancel = (fl != 0);
            @(negedge clk);
            ready_m = 1'b0; data_m = rand_line(); flush = 1'b0;
            check("fill_valid_drop", {31'b0, valid_m}, 32'd0);
            mdl_valid[idx] = 1'b1;
            mdl_laddr[idx] = a[31:4];
            mdl_line[idx]  = line;
            word = line[{a[3:2], 5'b00000} +: 32];
        end
        if (cancel) begin
            check("cancel_no_rsp", {31'b0, ready_f}, 32'd0);
        end else begin
            check("rsp_ready", {31'b0, ready_f}, 32'd1);
            check("rsp_inst", inst_f, word);
            if (stall) begin
                rdy = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("frz_ready", {31'b0, ready_f}, 32'd1);
                    check("frz_inst", inst_f, word);
                end
                rdy = 1'b1;
            end
            // A request in the response cycle must be ignored
            valid_f = 1'b1; addr_f = a ^ 32'h0000_0140;
            @(negedge clk);
            valid_f = 1'b0;
            check("pulse_end", {31'b0, ready_f}, 32'd0);
            check("rsp_cycle_ignored", {31'b0, valid_m}, 32'd0);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", {31'b0, ready_f}, 32'd0);
        check("rst_inst", inst_f, 32'd0);
        check("rst_valid", {31'b0, valid_m}, 32'd0);
        check("rst_addr", addr_m, 32'd0);
    endtask

    // Asynchronous reset pulse applied mid-cycle
    task automatic do_reset();
        rst = 1'b0;
        #1;
        check_reset_outputs();
        model_clear();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        int          sel;
        rst = 1'b0; rdy = 1'b1; flush = 1'b0; valid_f = 1'b0; addr_f = 32'd0;
        ready_m = 1'b0; data_m = 128'd0;
        model_clear();
        #1;
        check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Directed scenarios
        fetch(32'h0000_1004, 2, 0, 1'b0);     // miss, word1 = DEADBEEF
        fetch(32'h0000_100C, 0, 0, 1'b0);     // hit, word3
        fetch(32'h0000_2004, 1, 0, 1'b0);     // same index, new tag
        fetch(32'h0000_1004, 1, 0, 1'b0);     // evicted: misses again
        fetch(32'h0000_3000, 3, 1, 1'b0);     // flushed miss, still filled
        fetch(32'h0000_3000, 0, 0, 1'b0);     // now hits
        fetch(32'h0000_4008, 2, 2, 1'b0);     // flush with the line pulse
        fetch(32'h0000_5004, 5, 0, 1'b1);     // rdy stalls in MISS and pulse
        fetch(32'h0000_5004, 0, 0, 1'b1);     // rdy stall on a hit pulse

        // Flush in IDLE drops the request
        valid_f = 1'b1; flush = 1'b1; addr_f = 32'h0000_5008;
        @(negedge clk);
        valid_f = 1'b0; flush = 1'b0;
        check("idle_flush_rsp", {31'b0, ready_f}, 32'd0);
        check("idle_flush_fill", {31'b0, valid_m}, 32'd0);

        // No request, no activity
        repeat (3) begin
            addr_f = $urandom;
            @(negedge clk);
            check("idle_quiet_rsp", {31'b0, ready_f}, 32'd0);
            check("idle_quiet_fill", {31'b0, valid_m}, 32'd0);
        end

        // Reset while a fill is outstanding
        valid_f = 1'b1; addr_f = 32'h0000_6004;
        @(negedge clk);
        valid_f = 1'b0;
        check("pre_rst_valid", {31'b0, valid_m}, 32'd1);
        @(negedge clk);
        do_reset();
        fetch(32'h0000_6004, 1, 0, 1'b0);
        fetch(32'h0000_5004, 1, 0, 1'b0);

        // Randomized traffic over a small address pool to mix hits and misses
        for (int n = 0; n < 200; n++) begin
            a   = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4)
                | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            sel = $urandom_range(0, 19);
            if (sel == 0) begin
                do_reset();
            end else if (sel < 3) begin
                fetch(a, 1 + $urandom_range(0, 3), sel, 1'b0);
            end else if (sel == 3) begin
                fetch(a, 4 + $urandom_range(0, 2), 0, 1'b1);
            end else begin
                fetch(a, $urandom_range(0, 4), 0, 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
